// File: rtl/rr_priority_encoder_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
//   state_e    : arbiter FSM states (IDLE, GRANT)
//   MODE_FIXED : highest set request index wins
//   MODE_RR    : round-robin, previous winner gets lowest priority
//   idx_w()    : width of a grant index for N requesters
package rr_priority_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // At least one bit so N=1 corner cases still elaborate.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/grant bundle between requesters and the encoder.
//   req          : N request lines, bit i is requester i
//   mode         : MODE_FIXED / MODE_RR
//   ack          : consumer is done with the current grant
//   grant_valid  : a grant is held
//   grant_idx    : index of the granted requester
//   grant_onehot : one-hot form of grant_idx, zero when no grant
// master = requester/consumer side, slave = encoder side.
interface rr_priority_encoder_if
  import rr_priority_encoder_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = idx_w(N);

  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;

  modport master (
    output req, mode, ack,
    input  grant_valid, grant_idx, grant_onehot
  );

  modport slave (
    input  req, mode, ack,
    output grant_valid, grant_idx, grant_onehot
  );

endinterface

// File: rtl/rr_priority_encoder_prio_pick.sv
// Combinational winner selection.
//   req   : request lines
//   start : first index searched in round-robin mode (search runs downward)
//   mode  : MODE_FIXED ignores start and searches from N-1
//   idx   : winning index (don't-care when any = 0)
//   any   : at least one request is set
// req is rotated so that the start index lands in the MSB, an MSB-first
// pick runs on the rotated vector, and the result is rotated back.
module rr_priority_encoder_prio_pick
  import rr_priority_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] top_s;  // index that maps onto the rotated MSB
  logic [W:0]   sh;     // rotate amount, 1..N
  logic [N-1:0] rot;
  logic [W-1:0] pj;
  logic [W:0]   sum;

  always_comb begin
    top_s = (mode == MODE_RR) ? start : W'(N - 1);
    sh    = {1'b0, top_s} + (W+1)'(1);
    // Bit j of the doubled vector shifted by sh is req[(top_s+1+j) mod N],
    // so rot[N-1] = req[top_s], rot[N-2] = req[top_s-1], and so on.
    rot   = N'({req, req} >> sh);
    pj    = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) pj = W'(j);
    end
    sum   = {1'b0, pj} + sh;
    idx   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    any   = |req;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with grant/ack handshake.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : rr_priority_encoder_if slave modport (req/mode/ack in,
//         grant_valid/grant_idx/grant_onehot out)
// A winner is registered from IDLE, held unchanged through GRANT until ack,
// and recorded in last_ptr on release so round-robin continues after it.
// N must match the N of the connected interface instance.
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_priority_encoder_if.slave  bus
);

  state_e       state_q,        state_d;
  logic         grant_valid_q,  grant_valid_d;
  logic [W-1:0] grant_idx_q,    grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic [W-1:0] last_ptr_q,     last_ptr_d;

  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  // Round-robin search starts one below the previous winner, wrapping.
  always_comb begin
    start = (last_ptr_q == '0) ? W'(N - 1) : last_ptr_q - W'(1);
  end

  rr_priority_encoder_prio_pick #(.N(N)) u_prio_pick (
    .req   (bus.req),
    .start (start),
    .mode  (bus.mode),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    last_ptr_d     = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_valid_d  = 1'b1;
          grant_idx_d    = pick_idx;
          grant_onehot_d = N'(1) << pick_idx;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        // req and mode are ignored here; only ack ends the grant.
        if (bus.ack) begin
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
          last_ptr_d     = grant_idx_q;  // grant_idx itself is left as-is
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      last_ptr_q     <= '0;
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      last_ptr_q     <= last_ptr_d;
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed + randomized bench for rr_priority_encoder (N = 8). A per-cycle
// reference model tracks grant state and computes winners by a plain search
// over req; directed steps also compare against hand-derived constants.
module tb_rr_priority_encoder;
  import rr_priority_encoder_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_priority_encoder_if #(.N(N)) bus ();
  rr_priority_encoder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input logic md, input int last);
    if (md == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last - k + N) % N;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] exp_oh;
    exp_oh = m_valid ? (32'd1 << m_idx) : 32'd0;
    chk({tag, ".valid"},  32'(bus.grant_valid),  32'(m_valid));
    chk({tag, ".idx"},    32'(bus.grant_idx),    32'(m_idx));
    chk({tag, ".onehot"}, 32'(bus.grant_onehot), exp_oh);
  endtask

  // Advance the model with the current inputs, clock once, compare.
  task automatic tick(input string tag);
    if (!m_valid) begin
      if (bus.req != '0) begin
        m_idx   = winner(bus.req, bus.mode, m_last);
        m_valid = 1'b1;
      end
    end else if (bus.ack) begin
      m_valid = 1'b0;
      m_last  = m_idx;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_idx   = 0;
    m_last  = 0;
    check_outputs(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int rr_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int rr_got[$];

    rst      = 1'b1;
    bus.req  = '0;
    bus.mode = MODE_FIXED;
    bus.ack  = 1'b0;
    m_valid  = 1'b0;
    m_idx    = 0;
    m_last   = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // idle: no request, then ack while idle
    tick("idle_noreq");
    bus.ack = 1'b1;
    tick("idle_ack");
    bus.ack = 1'b0;
    tick("idle_noreq2");

    // fixed priority
    bus.req = 8'b0010_1000;
    tick("fixed");
    chk("fixed_idx5", 32'(bus.grant_idx), 32'd5);
    chk("fixed_oh20", 32'(bus.grant_onehot), 32'h20);
    bus.ack = 1'b1;
    tick("fixed_rel");
    chk("fixed_rel_valid", 32'(bus.grant_valid), 32'd0);
    bus.ack = 1'b0;
    bus.req = '0;
    tick("fixed_idle");

    // fixed starvation: idx 7 every grant, one idle cycle between
    bus.req = 8'hFF;
    bus.ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("starve");
      chk("starve_valid", 32'(bus.grant_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("starve_idx7", 32'(bus.grant_idx), 32'd7);
    end

    // reset while a grant is held
    bus.ack = 1'b0;
    tick("pre_reset_grant");
    async_reset("mid_grant_reset");

    // round-robin from reset, req all ones
    bus.mode = MODE_RR;
    bus.ack  = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick("rr");
      if (bus.grant_valid) rr_got.push_back(int'(bus.grant_idx));
    end
    chk("rr_count", 32'(rr_got.size()), 32'd9);
    for (int k = 0; k < 9 && k < rr_got.size(); k++)
      chk("rr_seq", 32'(rr_got[k]), 32'(rr_exp[k]));

    // sparse round-robin with last winner 2
    bus.req = '0;
    tick("drain");
    tick("drain");
    bus.ack = 1'b0;
    bus.req = 8'b0000_0100;
    tick("rr_set2");
    bus.ack = 1'b1;
    tick("rr_set2_rel");
    bus.ack = 1'b0;
    bus.req = 8'b0000_0101;
    tick("sparse1");
    chk("sparse_idx0", 32'(bus.grant_idx), 32'd0);
    bus.ack = 1'b1;
    tick("sparse1_rel");
    bus.ack = 1'b0;
    tick("sparse2");
    chk("sparse_idx2", 32'(bus.grant_idx), 32'd2);
    bus.ack = 1'b1;
    tick("sparse2_rel");
    bus.ack = 1'b0;
    bus.req = '0;
    tick("sparse_idle");

    // winner drops its request during GRANT
    bus.mode = MODE_FIXED;
    bus.req  = 8'h10;
    tick("drop_grant");
    bus.req = '0;
    tick("drop_hold");
    tick("drop_hold");
    bus.req = 8'h81;
    tick("drop_hold_newreq");
    chk("drop_held_idx4", 32'(bus.grant_idx), 32'd4);
    bus.ack = 1'b1;
    tick("drop_rel");
    bus.ack = 1'b0;

    // mode toggled during GRANT applies at next arbitration
    tick("mode_grant");
    chk("mode_fixed7", 32'(bus.grant_idx), 32'd7);
    bus.mode = MODE_RR;
    tick("mode_hold");
    chk("mode_hold7", 32'(bus.grant_idx), 32'd7);
    bus.ack = 1'b1;
    tick("mode_rel");
    bus.ack = 1'b0;
    tick("mode_next");
    chk("mode_rr0", 32'(bus.grant_idx), 32'd0);
    bus.ack = 1'b1;
    tick("mode_next_rel");

    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      bus.req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.mode = 1'($urandom);
      bus.ack  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised, registered N-input priority encoder with a grant/acknowledge handshake and a selectable fixed-priority or round-robin mode. It extends the combinational 8-to-3 MSB-first encoder with three additions:
- a held grant,
- a valid flag,
- fairness across requesters.

It sits in front of shared resources such as a bus or a decoder, where several requesters compete and the winner must stay stable until it is served.

## Interface
Parameters:
- N, 8, number of request lines (N ≥ 2).
- W, $clog2(N), width of the grant index. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  N  request lines; bit i is requester i.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- ack  input  1  consumer done with the current grant. Only meaningful while grant_valid = 1.
- grant_valid  output  1  a grant is held.
- grant_idx  output  W  index of the granted requester.
- grant_onehot  output  N  one-hot form of grant_idx. All zeros when grant_valid = 0.

## Operation
- FSM has two states: IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - If req ≠ 0, select a winner, register grant_idx and grant_onehot, set grant_valid, and go to GRANT.
  - If req = 0, stay in IDLE; outputs unchanged from their cleared values.
- GRANT:
  - Outputs are frozen. req changes are ignored, including the winner dropping its request.
  - If ack = 1, clear grant_valid and grant_onehot, record the winner in last_ptr, and go to IDLE.
  - grant_idx holds its last value after release; consumers qualify it with grant_valid.
- Fixed mode: the highest set bit of req wins (MSB-first, as in the 8x3 encoder).
- Round-robin mode:
  - Search req downward starting at index (last_ptr − 1) mod N, wrapping from 0 to N−1. The first set bit wins.
  - The previous winner therefore has the lowest priority.
- last_ptr:
  - Resets to 0, so the first round-robin search starts at N−1. Before any grant, round-robin gives the same result as fixed mode.
  - Updates on every release in both modes, so switching to round-robin continues from the latest winner.
- mode is sampled only in IDLE on an arbitration cycle. A change during GRANT takes effect at the next arbitration.
- ack while in IDLE is ignored.
- Reset asserted mid-grant:
  - Immediately clears grant_valid, grant_onehot, grant_idx and last_ptr, and sets the state to IDLE.
  - The interrupted grant is not resumed.

## Timing
- Reset values: grant_valid = 0, grant_idx = 0, grant_onehot = 0, last_ptr = 0, state = IDLE.
- Latency: req sampled nonzero at edge k (state IDLE) → grant_valid = 1 after edge k.
- Release: ack sampled high at edge m → grant_valid = 0 after edge m.
- Back-to-back grants:
  - Minimum one idle cycle between grants. The state is IDLE after edge m, arbitration happens at edge m+1, and the next grant is visible after edge m+1.
  - Peak throughput is one grant per two cycles when ack is returned in the first grant cycle.
- All outputs are registered. There is no combinational path from req, mode or ack to any output.

## Structure
- Shared package holds:
  - the state enum (IDLE, GRANT);
  - a helper for the index width;
  - the mode constants MODE_FIXED = 0 and MODE_RR = 1.
- One sub-module, prio_pick:
  - Combinational. Inputs: req, start index, mode. Outputs: winner index and any-flag.
  - Implemented by rotating req by the start index, running an MSB-first pick, then un-rotating the result.
  - The top level contains only the FSM, last_ptr and the output registers.

## Test plan
All scenarios use N = 8.
- Reset: assert rst mid-simulation with req = 8'hFF while a grant is held → all outputs 0 immediately; first grant after release of rst is idx 7.
- Fixed priority: mode = 0, req = 8'b0010_1000 → after one edge grant_valid = 1, grant_idx = 5, grant_onehot = 8'h20. ack for one cycle → grant_valid = 0 on the next edge.
- Fixed starvation: mode = 0, req = 8'hFF held, ack on every grant → grant_idx is 7 for every grant; one idle cycle between grants.
- Round-robin: mode = 1, req = 8'hFF held, ack on every grant → grant_idx sequence 7, 6, 5, 4, 3, 2, 1, 0, 7.
- Round-robin, sparse requests: mode = 1, last winner 2, req = 8'b0000_0101 → grant_idx 0. After that release, the same req → grant_idx 2.
- Handshake edges:
  - req = 0 → grant_valid stays 0.
  - ack pulsed while idle → no effect.
  - Winner drops req during GRANT → grant held until ack.
  - mode toggled during GRANT → the next arbitration uses the new mode.
